// File: rtl/fs_serial.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first, with start/busy/done handshake.
// Defining FS_SERIAL_OVF_EN adds the signed-overflow output ovf.
module fs_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef FS_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Full-subtractor cell, returns {borrow_out, difference_bit}.
    function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bin);
        fs_cell = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef FS_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    logic [1:0]       cell_s;
    logic             accept_s;

    // Next-state logic: accept in IDLE/DONE, one bit per edge in RUN, publish on entry to DONE.
    always_comb begin
        cell_s   = fs_cell(sa_q[0], sb_q[0], borrow_q);
        accept_s = start && ((state_q == IDLE) || (state_q == DONE));
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef FS_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d  = RUN;
                    sa_d     = a;
                    sb_d     = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                sa_d     = {1'b0, sa_q[WIDTH-1:1]};
                sb_d     = {1'b0, sb_q[WIDTH-1:1]};
                res_d    = {cell_s[0], res_q[WIDTH-1:1]};
                borrow_d = cell_s[1];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    diff_d  = {cell_s[0], res_q[WIDTH-1:1]};
                    bout_d  = cell_s[1];
`ifdef FS_SERIAL_OVF_EN
                    // On the last bit sa_q[0]/sb_q[0] are the captured operand MSBs.
                    ovf_d   = (sa_q[0] ^ sb_q[0]) & (cell_s[0] ^ sa_q[0]);
`endif
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef FS_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef FS_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef FS_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
